// File: rtl/eth_tx_length_framer_pkg.sv
// Shared constants and FSM state encodings for the TX length framer.
// Padding logic elsewhere is compiled in only with ETH_TX_LENGTH_FRAMER_PAD_EN.
package eth_tx_length_framer_pkg;

  localparam int LENGTH_WIDTH_DEFAULT  = 11;
  localparam int ETH_MAX_PACKET_LENGTH = 1522;
  localparam int ETH_MIN_PAYLOAD_PAD   = 60;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DATA = 2'd1;
  localparam state_t ST_PAD  = 2'd2;

endpackage

// File: rtl/eth_tx_length_framer_out_reg.sv
// Single-stage AXI-stream output register: one beat of storage with a
// combinational ready so a drained slot refills in the same cycle.
module eth_tx_length_framer_out_reg (
  input  logic       logic_clk,
  input  logic       logic_rst,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  input  logic       m_axis_tready
);

  assign in_ready = !m_axis_tvalid || m_axis_tready;

  // NOTE: data and last are reset too, so every output reads 0 out of reset
  // rather than whatever the flops powered up with.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (in_valid && in_ready) begin
      m_axis_tdata  <= in_data;
      m_axis_tlast  <= in_last;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_tx_length_framer.sv
// Turns a length descriptor plus an unterminated byte stream into an
// AXI-stream frame with tlast. Define ETH_TX_LENGTH_FRAMER_PAD_EN to pad short frames.
module eth_tx_length_framer #(
  parameter int LENGTH_WIDTH = eth_tx_length_framer_pkg::LENGTH_WIDTH_DEFAULT,
  parameter int MAX_LENGTH   = eth_tx_length_framer_pkg::ETH_MAX_PACKET_LENGTH,
  parameter int PAD_LENGTH   = eth_tx_length_framer_pkg::ETH_MIN_PAYLOAD_PAD
) (
  input  logic                    logic_clk,
  input  logic                    logic_rst,
  input  logic [LENGTH_WIDTH-1:0] s_len_tdata,
  input  logic                    s_len_tvalid,
  output logic                    s_len_tready,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    status_bad_length,
  output logic                    status_frame_done,
  output logic [31:0]             frame_count
);

  import eth_tx_length_framer_pkg::*;

  localparam logic [LENGTH_WIDTH-1:0] MAX_LEN = LENGTH_WIDTH'(MAX_LENGTH);
  localparam logic [LENGTH_WIDTH-1:0] ONE     = LENGTH_WIDTH'(1);

  state_t                  state;
  logic [LENGTH_WIDTH-1:0] remaining;
  logic                    len_hs;
  logic                    len_bad;
  logic                    out_ready;
  logic                    load_valid;
  logic                    load_last;
  logic [7:0]              load_data;
  logic                    load_hs;

`ifdef ETH_TX_LENGTH_FRAMER_PAD_EN
  localparam logic [LENGTH_WIDTH-1:0] PAD_LEN = LENGTH_WIDTH'(PAD_LENGTH);
  logic [LENGTH_WIDTH-1:0] pad_remaining;
`endif

  assign len_hs        = s_len_tvalid && s_len_tready;
  assign len_bad       = (s_len_tdata == '0) || (s_len_tdata > MAX_LEN);
  assign load_hs       = load_valid && out_ready;
  assign s_len_tready  = (state == ST_IDLE);
  assign s_axis_tready = (state == ST_DATA) && out_ready;
  assign m_axis_tuser  = 1'b0;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = s_axis_tdata;
    case (state)
      ST_DATA: begin
        load_valid = s_axis_tvalid;
`ifdef ETH_TX_LENGTH_FRAMER_PAD_EN
        load_last  = (remaining == ONE) && (pad_remaining == '0);
`else
        load_last  = (remaining == ONE);
`endif
      end
`ifdef ETH_TX_LENGTH_FRAMER_PAD_EN
      ST_PAD: begin
        load_valid = 1'b1;
        load_data  = 8'h00;
        load_last  = (pad_remaining == ONE);
      end
`endif
      default: ;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      state             <= ST_IDLE;
      remaining         <= '0;
      status_bad_length <= 1'b0;
`ifdef ETH_TX_LENGTH_FRAMER_PAD_EN
      pad_remaining     <= '0;
`endif
    end else begin
      status_bad_length <= len_hs && len_bad;
      case (state)
        ST_IDLE: begin
          if (len_hs && !len_bad) begin
            remaining <= s_len_tdata;
            state     <= ST_DATA;
`ifdef ETH_TX_LENGTH_FRAMER_PAD_EN
            pad_remaining <= (s_len_tdata < PAD_LEN) ? PAD_LEN - s_len_tdata : '0;
`endif
          end
        end
        ST_DATA: begin
          if (load_hs) begin
            if (remaining != '0) remaining <= remaining - ONE;
            if (remaining == ONE) begin
`ifdef ETH_TX_LENGTH_FRAMER_PAD_EN
              state <= (pad_remaining != '0) ? ST_PAD : ST_IDLE;
`else
              state <= ST_IDLE;
`endif
            end
          end
        end
`ifdef ETH_TX_LENGTH_FRAMER_PAD_EN
        ST_PAD: begin
          if (load_hs) begin
            if (pad_remaining != '0) pad_remaining <= pad_remaining - ONE;
            if (pad_remaining == ONE) state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame statistics follow the output handshake, not the input side.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      status_frame_done <= 1'b0;
      frame_count       <= 32'd0;
    end else begin
      status_frame_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_count <= frame_count + 32'd1;
    end
  end

  eth_tx_length_framer_out_reg u_out_reg (
    .logic_clk     (logic_clk),
    .logic_rst     (logic_rst),
    .in_data       (load_data),
    .in_last       (load_last),
    .in_valid      (load_valid),
    .in_ready      (out_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

endmodule
